regfile_port_ctrl: RTL and testbench
====================================

# regfile_port_ctrl

Access controller for the integer register file: shares its single write port between two writeback requesters (w0 = ALU writeback, w1 = load/CSR writeback) and issues read-pair requests onto its two read ports. The register file silently drops a read whose address collides with a same-cycle write, so this block schedules writes around issued reads to prevent that collision. It also enforces x0 semantics, which the register file does not. It sits between the pipeline's decode/writeback stages and the register file.

## Interface
- STARVE_MAX, 4, consecutive cycles a pending write may be blocked before reads are stalled (1..15)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- w0_valid / w1_valid  in  1  write request valid
- w0_addr / w1_addr  in  5  destination register
- w0_data / w1_data  in  32  write data
- w0_ready / w1_ready  out  1  request accepted this cycle (combinational)
- r_valid  in  1  read-pair request valid
- r_addr1 / r_addr2  in  5  source registers
- r_ready  out  1  read accepted this cycle (combinational)
- r_data_valid  out  1  r_data1/r_data2 valid (registered)
- r_data1 / r_data2  out  32  read results, x0 forced to 0
- rf_ra1 / rf_ra2  out  5  register file read addresses
- rf_wa1  out  5  register file write address
- rf_wd1  out  32  register file write data
- rf_we  out  1  register file write enable
- rf_rd1 / rf_rd2  in  32  register file read data

## Operation
- Read issue: rd_issue = r_valid && !force_write. r_ready = !force_write. rf_ra1/rf_ra2 = r_addr1/r_addr2 at all times.
- Conflict: write i conflicts when rd_issue is high, wi_addr != 0, and wi_addr equals r_addr1 or r_addr2.
- Eligible write: eligible_i = wi_valid && !conflict_i. A conflicting write waits; the read wins.
- Arbitration: 2-way round-robin among eligible requesters, at most one grant per cycle. rr_ptr selects the preferred requester. On a grant to i, rr_ptr takes the value of the other requester. Without a grant, rr_ptr holds.
- Grant to i: wi_ready = 1. rf_wa1 = wi_addr and rf_wd1 = wi_data. rf_we = (wi_addr != 0). A write to x0 is accepted and discarded.
- Starvation guard: starve_cnt increments in each cycle where (w0_valid || w1_valid) is high and no grant is made. It clears on any grant or when no write is valid. force_write = (starve_cnt == STARVE_MAX). While force_write is high, no read issues, so a grant is guaranteed that cycle.
- Read return: r_data_valid is registered from rd_issue. Two flags z1/z2 are registered from (r_addr1 == 0) and (r_addr2 == 0). r_data1 = z1 ? 0 : rf_rd1, and r_data2 = z2 ? 0 : rf_rd2.
- Reset (synchronous, rst high):
  - rr_ptr = 0 (w0 preferred), starve_cnt = 0, r_data_valid = 0, z1 = z2 = 0.
  - While rst is high, w0_ready, w1_ready, r_ready and rf_we are forced to 0.

## Timing
- Write: granted in cycle N, committed at edge N, visible to a read issued in cycle N+1 or later.
- Read: issued in cycle N; r_data_valid = 1 in cycle N+1 with data. Back-to-back reads sustain one per cycle.
- Same-cycle write and read to the same register: the write is deferred by at least one cycle. The read returns the old value.
- Worst-case write wait under continuous conflicting reads: STARVE_MAX + 1 cycles.
- Reset asserted mid-operation: any grant in that cycle is suppressed, and the r_data_valid following a reset cycle is 0.

## Structure
- Package regfile_ctrl_pkg holds these constants: XLEN = 32, REG_AW = 5, ZERO_REG = 5'd0.
- Sub-module rr_arb2 implements the 2-requester round-robin (req[1:0], pointer register, grant one-hot). The top level holds the conflict logic, starvation counter, and read-return registers.

## Test plan
- Both writers valid, no reads, w0 → x5 = 0x11, w1 → x6 = 0x22:
  - Expect a grant to w0 in cycle 0, then w1 in cycle 1.
  - A subsequent read of x5/x6 returns 0x11/0x22.
- w0 writes x0 = 0xDEAD:
  - Expect w0_ready = 1 and rf_we = 0.
  - A read of x0 then returns 0 on r_data1.
- Read x7/x8 with w1 → x7 = 0x55 in the same cycle:
  - Expect r_ready = 1 and w1_ready = 0.
  - The next cycle returns the old x7, and w1 is granted.
  - A later read returns 0x55.
- With STARVE_MAX = 4, r_valid held high with r_addr1 = x9 while w0 → x9 is pending:
  - Expect w0 blocked for 4 cycles.
  - In cycle 5: r_ready = 0, w0_ready = 1, rf_we = 1.
- Both writers continuously valid on non-conflicting registers:
  - Expect strictly alternating grants, w0, w1, w0, … after reset.
- Assert rst during a pending read and write:
  - Expect all readys and rf_we at 0.
  - Expect r_data_valid = 0 in the following cycle.
  - After release, w0 is preferred.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the register-file port controller.
package regfile_ctrl_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the preferred requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (ptr_q == 1'b0) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
    end else begin
      if (req_i[1])      gnt_o = 2'b10;
      else if (req_i[0]) gnt_o = 2'b01;
    end
  end

  // After serving one requester, prefer the other.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Shares the register-file write port between two writers, schedules writes
// around issued reads to avoid same-address collisions, and enforces x0.
module regfile_port_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w0_valid,
  input  logic [REG_AW-1:0] w0_addr,
  input  logic [XLEN-1:0]   w0_data,
  output logic              w0_ready,
  input  logic              w1_valid,
  input  logic [REG_AW-1:0] w1_addr,
  input  logic [XLEN-1:0]   w1_data,
  output logic              w1_ready,
  input  logic              r_valid,
  input  logic [REG_AW-1:0] r_addr1,
  input  logic [REG_AW-1:0] r_addr2,
  output logic              r_ready,
  output logic              r_data_valid,
  output logic [XLEN-1:0]   r_data1,
  output logic [XLEN-1:0]   r_data2,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  output logic [REG_AW-1:0] rf_wa1,
  output logic [XLEN-1:0]   rf_wd1,
  output logic              rf_we,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rdv_q, z1_q, z2_q;
  logic       force_write, rd_issue;
  logic       conflict0, conflict1;
  logic [1:0] eligible, gnt;

  assign force_write = (starve_cnt_q == StarveMax);
  assign rd_issue    = r_valid && !force_write;
  assign r_ready     = !force_write && !rst;
  assign rf_ra1      = r_addr1;
  assign rf_ra2      = r_addr2;

  assign conflict0 = rd_issue && (w0_addr != ZERO_REG) &&
                     ((w0_addr == r_addr1) || (w0_addr == r_addr2));
  assign conflict1 = rd_issue && (w1_addr != ZERO_REG) &&
                     ((w1_addr == r_addr1) || (w1_addr == r_addr2));
  assign eligible  = {w1_valid && !conflict1, w0_valid && !conflict0};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (eligible),
    .gnt_o (gnt)
  );

  assign w0_ready = gnt[0] && !rst;
  assign w1_ready = gnt[1] && !rst;
  assign rf_wa1   = gnt[1] ? w1_addr : w0_addr;
  assign rf_wd1   = gnt[1] ? w1_data : w0_data;
  // Writes to x0 are accepted but never reach the register file.
  assign rf_we    = (|gnt) && (rf_wa1 != ZERO_REG) && !rst;

  always_comb begin
    starve_cnt_d = 4'd0;
    if (!(|gnt) && (w0_valid || w1_valid)) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rdv_q        <= 1'b0;
      z1_q         <= 1'b0;
      z2_q         <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rdv_q        <= rd_issue;
      z1_q         <= (r_addr1 == ZERO_REG);
      z2_q         <= (r_addr2 == ZERO_REG);
    end
  end

  assign r_data_valid = rdv_q;
  assign r_data1      = z1_q ? '0 : rf_rd1;
  assign r_data2      = z2_q ? '0 : rf_rd2;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a synchronous-read register file model.
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        w0_valid, w1_valid, r_valid;
  logic [4:0]  w0_addr, w1_addr, r_addr1, r_addr2;
  logic [31:0] w0_data, w1_data;
  logic        w0_ready, w1_ready, r_ready, r_data_valid, rf_we;
  logic [31:0] r_data1, r_data2, rf_wd1, rf_rd1, rf_rd2;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_port_ctrl #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .w0_valid     (w0_valid),
    .w0_addr      (w0_addr),
    .w0_data      (w0_data),
    .w0_ready     (w0_ready),
    .w1_valid     (w1_valid),
    .w1_addr      (w1_addr),
    .w1_data      (w1_data),
    .w1_ready     (w1_ready),
    .r_valid      (r_valid),
    .r_addr1      (r_addr1),
    .r_addr2      (r_addr2),
    .r_ready      (r_ready),
    .r_data_valid (r_data_valid),
    .r_data1      (r_data1),
    .r_data2      (r_data2),
    .rf_ra1       (rf_ra1),
    .rf_ra2       (rf_ra2),
    .rf_wa1       (rf_wa1),
    .rf_wd1       (rf_wd1),
    .rf_we        (rf_we),
    .rf_rd1       (rf_rd1),
    .rf_rd2       (rf_rd2)
  );

  // Register file: registered read, read-before-write, colliding read is lost.
  // x0 holds a nonzero value so the controller's zero forcing is visible.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
    end else begin
      rf_rd1 <= (rf_we && rf_wa1 == rf_ra1) ? 32'hxxxx_xxxx : mem[rf_ra1];
      rf_rd2 <= (rf_we && rf_wa1 == rf_ra2) ? 32'hxxxx_xxxx : mem[rf_ra2];
      if (rf_we) mem[rf_wa1] <= rf_wd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    w0_valid = 0; w0_addr = 0; w0_data = 0;
    w1_valid = 0; w1_addr = 0; w1_data = 0;
    r_valid = 0; r_addr1 = 0; r_addr2 = 0;
    tick(); tick();
    chk("reset_rdv", {31'b0, r_data_valid}, 32'd0);
    chk("reset_rready", {31'b0, r_ready}, 32'd0);

    // Both writers, w0 preferred first.
    rst = 1'b0;
    w0_valid = 1; w0_addr = 5; w0_data = 32'h11;
    w1_valid = 1; w1_addr = 6; w1_data = 32'h22;
    #1;
    chk("rr_c0_w0", {31'b0, w0_ready}, 32'd1);
    chk("rr_c0_w1", {31'b0, w1_ready}, 32'd0);
    chk("rr_c0_wa", {27'b0, rf_wa1}, 32'd5);
    tick();
    w0_valid = 0;
    #1;
    chk("rr_c1_w1", {31'b0, w1_ready}, 32'd1);
    chk("rr_c1_wd", rf_wd1, 32'h22);
    chk("rr_c1_we", {31'b0, rf_we}, 32'd1);
    tick();
    w1_valid = 0;
    r_valid = 1; r_addr1 = 5; r_addr2 = 6;
    #1;
    chk("rd56_ready", {31'b0, r_ready}, 32'd1);
    tick();
    r_valid = 0;
    chk("rd56_valid", {31'b0, r_data_valid}, 32'd1);
    chk("rd56_d1", r_data1, 32'h11);
    chk("rd56_d2", r_data2, 32'h22);

    // Write to x0 is accepted and dropped.
    w0_valid = 1; w0_addr = 0; w0_data = 32'hDEAD;
    #1;
    chk("x0_ready", {31'b0, w0_ready}, 32'd1);
    chk("x0_we", {31'b0, rf_we}, 32'd0);
    tick();
    w0_valid = 0;
    r_valid = 1; r_addr1 = 0; r_addr2 = 5;
    tick();
    r_valid = 0;
    chk("x0_rd1", r_data1, 32'd0);
    chk("x0_rd2", r_data2, 32'h11);

    // Same-cycle read/write collision defers the write.
    r_valid = 1; r_addr1 = 7; r_addr2 = 8;
    w1_valid = 1; w1_addr = 7; w1_data = 32'h55;
    #1;
    chk("col_rready", {31'b0, r_ready}, 32'd1);
    chk("col_w1ready", {31'b0, w1_ready}, 32'd0);
    chk("col_we", {31'b0, rf_we}, 32'd0);
    tick();
    r_valid = 0;
    #1;
    chk("col_rdv", {31'b0, r_data_valid}, 32'd1);
    chk("col_old7", r_data1, 32'hA000_0007);
    chk("col_old8", r_data2, 32'hA000_0008);
    chk("col_w1late", {31'b0, w1_ready}, 32'd1);
    chk("col_welate", {31'b0, rf_we}, 32'd1);
    tick();
    w1_valid = 0;
    r_valid = 1; r_addr1 = 7; r_addr2 = 8;
    tick();
    r_valid = 0;
    chk("col_new7", r_data1, 32'h55);

    // Starvation: four blocked cycles, then the write is forced.
    r_valid = 1; r_addr1 = 9; r_addr2 = 10;
    w0_valid = 1; w0_addr = 9; w0_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stv_blocked", {31'b0, w0_ready}, 32'd0);
      chk("stv_rready", {31'b0, r_ready}, 32'd1);
      if (i > 0) chk("stv_old9", r_data1, 32'hA000_0009);
      tick();
    end
    #1;
    chk("stv_force_rready", {31'b0, r_ready}, 32'd0);
    chk("stv_force_w0", {31'b0, w0_ready}, 32'd1);
    chk("stv_force_we", {31'b0, rf_we}, 32'd1);
    chk("stv_force_wa", {27'b0, rf_wa1}, 32'd9);
    tick();
    w0_valid = 0;
    chk("stv_noread", {31'b0, r_data_valid}, 32'd0);
    tick();
    r_valid = 0;
    chk("stv_new9", r_data1, 32'h99);

    // Reset during a pending read and writes.
    r_valid = 1; r_addr1 = 3; r_addr2 = 4;
    w0_valid = 1; w0_addr = 11; w0_data = 32'h111;
    w1_valid = 1; w1_addr = 12; w1_data = 32'h222;
    rst = 1;
    #1;
    chk("rst_w0", {31'b0, w0_ready}, 32'd0);
    chk("rst_w1", {31'b0, w1_ready}, 32'd0);
    chk("rst_r", {31'b0, r_ready}, 32'd0);
    chk("rst_we", {31'b0, rf_we}, 32'd0);
    tick();
    rst = 0;
    r_valid = 0;
    #1;
    chk("rst_rdv", {31'b0, r_data_valid}, 32'd0);

    // Continuous non-conflicting writers alternate starting with w0.
    for (int i = 0; i < 6; i++) begin
      chk("alt_w0", {31'b0, w0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_w1", {31'b0, w1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    w0_valid = 0; w1_valid = 0;
    r_valid = 1; r_addr1 = 11; r_addr2 = 12;
    tick();
    r_valid = 0;
    chk("alt_rd11", r_data1, 32'h111);
    chk("alt_rd12", r_data2, 32'h222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
